// File: rtl/key_pkg.sv
// Shared types and constants for the keypad tick sampler.
// Optional feature macro: KEY_AUTO_REPEAT_EN (hold-to-repeat).
package key_pkg;

  localparam int unsigned KEY_CNT_W   = 4;
  localparam int unsigned KEY_CNT_MAX = 15;

  typedef logic [KEY_CNT_W-1:0] key_cnt_t;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } key_state_t;

  // Increment that sticks at KEY_CNT_MAX instead of wrapping.
  function automatic key_cnt_t cnt_sat_inc(input key_cnt_t c);
    return (c == key_cnt_t'(KEY_CNT_MAX)) ? c : c + key_cnt_t'(1);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key's debounce FSM, advanced only on sample ticks.
// Optional feature macro: KEY_AUTO_REPEAT_EN adds the REPEAT state and rcnt.
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 2
`ifdef KEY_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY   = 3,
  parameter int unsigned REPEAT_RATE    = 1
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic sample,
  output logic level,
  output logic pulse,
  output logic pulse_c
);

  localparam key_cnt_t DB_THR = key_cnt_t'(DEBOUNCE_TICKS);
`ifdef KEY_AUTO_REPEAT_EN
  localparam key_cnt_t RD_THR = key_cnt_t'(REPEAT_DELAY);
  localparam key_cnt_t RR_THR = key_cnt_t'(REPEAT_RATE);
`endif

  key_state_t state_q, state_d;
  key_cnt_t   cnt_q, cnt_d, cnt_inc;
  logic       level_q, level_d;
  logic       pulse_q, pulse_d;
`ifdef KEY_AUTO_REPEAT_EN
  key_cnt_t   rcnt_q, rcnt_d, rcnt_inc;
`endif

  // Next-state, counters and press/repeat pulse decision for this key.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    pulse_d  = 1'b0;
    cnt_inc  = cnt_sat_inc(cnt_q);
`ifdef KEY_AUTO_REPEAT_EN
    rcnt_d   = rcnt_q;
    rcnt_inc = cnt_sat_inc(rcnt_q);
`endif
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (sample) begin
            if (DB_THR <= key_cnt_t'(1)) begin
              state_d = HELD;
              level_d = 1'b1;
              pulse_d = 1'b1;
              cnt_d   = '0;
`ifdef KEY_AUTO_REPEAT_EN
              rcnt_d  = '0;
`endif
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = key_cnt_t'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (!sample) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc >= DB_THR) begin
            state_d = HELD;
            level_d = 1'b1;
            pulse_d = 1'b1;
            cnt_d   = '0;
`ifdef KEY_AUTO_REPEAT_EN
            rcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          if (!sample) begin
            // A single-tick debounce releases on the first low sample.
            if (DB_THR <= key_cnt_t'(1)) begin
              state_d = IDLE;
              level_d = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE_WAIT;
              cnt_d   = key_cnt_t'(1);
            end
          end
`ifdef KEY_AUTO_REPEAT_EN
          else if (rcnt_inc >= RD_THR) begin
            state_d = REPEAT;
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_inc;
          end
`endif
        end
`ifdef KEY_AUTO_REPEAT_EN
        REPEAT: begin
          if (!sample) begin
            if (DB_THR <= key_cnt_t'(1)) begin
              state_d = IDLE;
              level_d = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE_WAIT;
              cnt_d   = key_cnt_t'(1);
            end
            rcnt_d = '0;
          end else if (rcnt_inc >= RR_THR) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_inc;
          end
        end
`endif
        RELEASE_WAIT: begin
          if (sample) begin
            // Bounce during release returns to HELD without a new pulse.
            state_d = HELD;
            cnt_d   = '0;
`ifdef KEY_AUTO_REPEAT_EN
            rcnt_d  = '0;
`endif
          end else if (cnt_inc >= DB_THR) begin
            state_d = IDLE;
            level_d = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers; reset discards all progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
`ifdef KEY_AUTO_REPEAT_EN
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  assign level   = level_q;
  assign pulse   = pulse_q;
  assign pulse_c = pulse_d;

endmodule

// File: rtl/key_tick_sampler.sv
// Slow-clock tick generator and per-key debouncers for the calculator keypad.
// Optional feature macro: KEY_AUTO_REPEAT_EN enables hold-to-repeat pulses.
module key_tick_sampler
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS         = 4,
  parameter int unsigned DEBOUNCE_TICKS = 2,
  parameter int unsigned REPEAT_DELAY   = 3,
  parameter int unsigned REPEAT_RATE    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              slow_clk,
  input  logic [N_KEYS-1:0] keys_in,
  output logic              tick,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_pulse,
  output logic              any_pulse
);

  localparam bit CFG_OK = (N_KEYS >= 1) && (N_KEYS <= 16) &&
                          (DEBOUNCE_TICKS >= 1) && (DEBOUNCE_TICKS <= KEY_CNT_MAX) &&
                          (REPEAT_DELAY >= 1) && (REPEAT_DELAY <= KEY_CNT_MAX) &&
                          (REPEAT_RATE >= 1) && (REPEAT_RATE <= KEY_CNT_MAX);

  // Out-of-range parameters show up as this named scope in the elaborated hierarchy.
  if (!CFG_OK) begin : g_bad_config
  end

  logic              slow_meta_q, slow_meta_d;
  logic              slow_sync_q, slow_sync_d;
  logic              slow_prev_q, slow_prev_d;
  logic              tick_q, tick_d;
  logic [N_KEYS-1:0] keys_meta_q, keys_meta_d;
  logic [N_KEYS-1:0] keys_sync_q, keys_sync_d;
  logic              any_pulse_q, any_pulse_d;
  logic [N_KEYS-1:0] pulse_c;

  // Synchronizer chains, rising-edge detect on slow_clk, and the pulse OR.
  always_comb begin
    slow_meta_d = slow_clk;
    slow_sync_d = slow_meta_q;
    slow_prev_d = slow_sync_q;
    tick_d      = slow_sync_q & ~slow_prev_q;
    keys_meta_d = keys_in;
    keys_sync_d = keys_meta_q;
    any_pulse_d = |pulse_c;
  end

  // Front-end registers; all synchronizer stages clear on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slow_meta_q <= 1'b0;
      slow_sync_q <= 1'b0;
      slow_prev_q <= 1'b0;
      tick_q      <= 1'b0;
      keys_meta_q <= '0;
      keys_sync_q <= '0;
      any_pulse_q <= 1'b0;
    end else begin
      slow_meta_q <= slow_meta_d;
      slow_sync_q <= slow_sync_d;
      slow_prev_q <= slow_prev_d;
      tick_q      <= tick_d;
      keys_meta_q <= keys_meta_d;
      keys_sync_q <= keys_sync_d;
      any_pulse_q <= any_pulse_d;
    end
  end

  for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
`ifdef KEY_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE)
`endif
    ) u_cell (
      .clock  (clock),
      .reset  (reset),
      .tick   (tick_q),
      .sample (keys_sync_q[i]),
      .level  (key_level[i]),
      .pulse  (key_pulse[i]),
      .pulse_c(pulse_c[i])
    );
  end

  assign tick      = tick_q;
  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_key_tick_sampler.sv
// Scoreboard bench for key_tick_sampler; repeat expectations follow KEY_AUTO_REPEAT_EN.
module tb_key_tick_sampler;

  typedef struct packed {
    logic [3:0] p;
    logic [3:0] l;
    logic       a;
  } exp_t;

`ifdef KEY_AUTO_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       slow_clk = 1'b0;
  logic [3:0] keys_in = 4'b0000;
  logic       tick;
  logic [3:0] key_level;
  logic [3:0] key_pulse;
  logic       any_pulse;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rise_cyc = -100;
  bit   rise_ok = 1'b0;
  logic [3:0] rp;

  key_tick_sampler dut (
    .clock    (clock),
    .reset    (reset),
    .slow_clk (slow_clk),
    .keys_in  (keys_in),
    .tick     (tick),
    .key_level(key_level),
    .key_pulse(key_pulse),
    .any_pulse(any_pulse)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // slow_clk toggles every 8 clocks; remember where each rise lands.
  initial begin
    forever begin
      repeat (8) @(posedge clock);
      #1 slow_clk = ~slow_clk;
      if (slow_clk) begin
        rise_cyc = cyc;
        rise_ok  = !reset;
      end
    end
  end

  // Tick timing every cycle; scoreboard pop on the cycle after each expected tick.
  always @(negedge clock) begin
    chk("tick", 32'(tick), 32'(rise_ok && (cyc == rise_cyc + 3)));
    if (rise_ok && (cyc == rise_cyc + 4)) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("key_pulse", 32'(key_pulse), 32'(e.p));
        chk("key_level", 32'(key_level), 32'(e.l));
        chk("any_pulse", 32'(any_pulse), 32'(e.a));
      end
    end else begin
      chk("pulse_idle", 32'({any_pulse, key_pulse}), 32'd0);
    end
  end

  // Drive keys for the next tick and queue what that tick must produce.
  task automatic step(input logic [3:0] k, input logic [3:0] ep, input logic [3:0] el);
    exp_t e;
    keys_in = k;
    e.p = ep;
    e.l = el;
    e.a = |ep;
    sb_q.push_back(e);
    @(negedge slow_clk);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_level", 32'(key_level), 32'd0);
    chk("rst_pulse", 32'(key_pulse), 32'd0);
    chk("rst_any",   32'(any_pulse), 32'd0);
    chk("rst_tick",  32'(tick),      32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    rp = RPT ? 4'b0100 : 4'b0000;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("init_tick",  32'(tick),      32'd0);
    chk("init_level", 32'(key_level), 32'd0);
    chk("init_pulse", 32'(key_pulse), 32'd0);
    chk("init_any",   32'(any_pulse), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // idle first tick, then key0 steady press and release
    step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0001, 4'b0000, 4'b0000);
    step(4'b0001, 4'b0001, 4'b0001);
    step(4'b0000, 4'b0000, 4'b0001);
    step(4'b0000, 4'b0000, 4'b0000);
    // key1 chatter never accepted
    step(4'b0010, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    step(4'b0010, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000);
    // key2 held 8 ticks: press, then repeats at +3..+6
    step(4'b0100, 4'b0000, 4'b0000);
    step(4'b0100, 4'b0100, 4'b0100);
    step(4'b0100, 4'b0000, 4'b0100);
    step(4'b0100, 4'b0000, 4'b0100);
    step(4'b0100, rp,      4'b0100);
    step(4'b0100, rp,      4'b0100);
    step(4'b0100, rp,      4'b0100);
    step(4'b0100, rp,      4'b0100);
    step(4'b0000, 4'b0000, 4'b0100);
    step(4'b0000, 4'b0000, 4'b0000);
    // key0 and key3 together
    step(4'b1001, 4'b0000, 4'b0000);
    step(4'b1001, 4'b1001, 4'b1001);
    step(4'b0000, 4'b0000, 4'b1001);
    step(4'b0000, 4'b0000, 4'b0000);
    // release bounce does not re-trigger
    step(4'b0001, 4'b0000, 4'b0000);
    step(4'b0001, 4'b0001, 4'b0001);
    step(4'b0000, 4'b0000, 4'b0001);
    step(4'b0001, 4'b0000, 4'b0001);
    step(4'b0000, 4'b0000, 4'b0001);
    step(4'b0000, 4'b0000, 4'b0000);
    // reset in PRESS_WAIT discards the first agreeing tick
    step(4'b0001, 4'b0000, 4'b0000);
    pulse_reset();
    step(4'b0001, 4'b0000, 4'b0000);
    step(4'b0001, 4'b0001, 4'b0001);
    // reset while held: level drops at once, key re-debounced afterwards
    pulse_reset();
    step(4'b0001, 4'b0000, 4'b0000);
    step(4'b0001, 4'b0001, 4'b0001);
    step(4'b0000, 4'b0000, 4'b0001);
    step(4'b0000, 4'b0000, 4'b0000);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_tick_sampler.md
# key_tick_sampler

Consumer end of the divided slow-clock chain: takes the 5 Hz divided clock level and the raw calculator keypad lines, all in the fast `clock` domain. Converts each slow-clock rising edge into a one-cycle sample tick and debounces every key on those ticks. Emits one-cycle press pulses, optionally with hold-to-repeat, to the calculator's operand/operator entry logic.

## Interface
- `N_KEYS`, 4: number of key lines, 1–16.
- `DEBOUNCE_TICKS`, 2: consecutive agreeing ticks needed to accept a press or release, 1–15.
- `REPEAT_DELAY`, 3: held ticks before the first repeat pulse, 1–15. At 5 Hz this is 600 ms.
- `REPEAT_RATE`, 1: ticks between later repeat pulses, 1–15.
- `clock` in 1: system clock. Everything is rising-edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `slow_clk` in 1: divided 5 Hz level. Treated as asynchronous.
- `keys_in` in N_KEYS: raw active-high buttons. Asynchronous.
- `tick` out 1: one-cycle strobe per `slow_clk` rising edge.
- `key_level` out N_KEYS: debounced key state.
- `key_pulse` out N_KEYS: one-cycle press and repeat pulses.
- `any_pulse` out 1: OR of `key_pulse`, registered with it.

## Operation
- `slow_clk` and every `keys_in` bit pass through 2-flop synchronizers. All synchronizer flops reset to 0.
- `tick` = synchronized `slow_clk` high and previous synchronized value low, registered.
- Each key has its own FSM. Key FSMs act only on cycles where `tick` is 1, and sample the synchronized key bit.
- `cnt` is a 4-bit debounce counter. `rcnt` is a 4-bit repeat counter.
- IDLE (level 0):
  - sample 1 → PRESS_WAIT, `cnt`=1.
  - If `DEBOUNCE_TICKS`=1, go straight to HELD with a pulse.
- PRESS_WAIT:
  - sample 1 → `cnt`++.
  - When `cnt` reaches `DEBOUNCE_TICKS` → HELD, set level 1, pulse, `rcnt`=0.
  - sample 0 → IDLE, `cnt`=0. No pulse.
- HELD (level 1):
  - sample 0 → RELEASE_WAIT, `cnt`=1.
  - sample 1 → `rcnt`++ (auto-repeat only).
  - When `rcnt` reaches `REPEAT_DELAY` → pulse, REPEAT, `rcnt`=0.
- REPEAT (level 1):
  - sample 1 → `rcnt`++.
  - When `rcnt` reaches `REPEAT_RATE` → pulse, `rcnt`=0.
  - sample 0 → RELEASE_WAIT, `cnt`=1.
- RELEASE_WAIT (level 1):
  - sample 0 → `cnt`++.
  - When `cnt` reaches `DEBOUNCE_TICKS` → IDLE, level 0.
  - sample 1 → HELD, `rcnt`=0. No pulse; a bounce on release never re-triggers.
- Keys are fully independent. Simultaneous presses produce simultaneous pulses on the same cycle.
- Counters saturate at 15 and never wrap.
- Reset mid-debounce or mid-repeat discards all progress. No pulse is emitted on reset entry or exit.
- A key held through reset release is seen as a new press and is debounced normally.

## Timing
- Reset values: `tick`, `key_level`, `key_pulse` and `any_pulse` are all 0. All FSMs are in IDLE with counters at 0.
- `tick` rises on the 3rd `clock` edge after `slow_clk` rises (2 synchronizer stages plus 1 register). It is high for exactly 1 cycle.
- `key_pulse` and `key_level` update on the clock edge following the deciding `tick`, i.e. 1 cycle after `tick`.
- `key_pulse` is exactly 1 cycle wide. Pulses are at least one tick period apart.
- A key change must be stable in the synchronizer before the tick cycle to be counted on that tick.
- Press latency, with the key stable before the first tick: `DEBOUNCE_TICKS` ticks. At defaults this is 400 ms.

## Configuration
- `KEY_AUTO_REPEAT_EN` defined:
  - HELD/REPEAT repeat logic and `rcnt` are compiled in.
- `KEY_AUTO_REPEAT_EN` undefined:
  - REPEAT state and `rcnt` are removed.
  - HELD waits only for release, giving exactly one pulse per accepted press.
  - `REPEAT_DELAY` and `REPEAT_RATE` are ignored.

## Structure
- Shared package `key_pkg`:
  - `key_state_t` enum: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT.
  - `KEY_CNT_W` = 4.
  - `KEY_CNT_MAX` = 15.
- Sub-module `key_debounce_cell`:
  - Holds one key's FSM, counters and output register.
  - Instantiated `N_KEYS` times in a generate loop.
- The top level holds the synchronizers, the tick edge detector and the `any_pulse` OR/register.

## Test plan
- Bench setup: `slow_clk` toggles every 8 clocks; defaults apply; `KEY_AUTO_REPEAT_EN` is defined.
- Reset release with `slow_clk` low and keys 0 → all outputs 0. First `tick` arrives 3 cycles after the first `slow_clk` rise.
- Key0 held steady → one `key_pulse`=4'b0001 one cycle after the 2nd tick. `key_level[0]` rises on the same edge.
- Key1 toggles 1,0,1 on consecutive ticks → no pulse, `key_level[1]` stays 0.
- Key2 held for 8 ticks → press pulse, then repeats at ticks +3, +4, +5, +6 after the press. Release → level drops 2 ticks after release.
- Key0 and key3 pressed together → `key_pulse`=4'b1001 on a single cycle, `any_pulse`=1.
- Reset asserted while key0 is in PRESS_WAIT (`cnt`=1) → outputs 0 immediately. After release, the press needs a full 2 fresh ticks.
